wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
- Sits between the UART-to-Wishbone bridge and the two memories, which are instruction and data.
- Arbitrates each memory between core traffic and bridge traffic.
- By default the core owns both memories. A bridge request stalls the core, routes one Wishbone classic transfer to the memory chosen by select_mem, and then returns ownership to the core.
- Provides an error response for out-of-range addresses and for memories that do not answer.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, bridge and core address width.
- MEM_ADDR_WIDTH, 10, word-address width of each memory.
- TIMEOUT, 255, maximum number of cycles to wait for a memory ack (8-bit counter, legal range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- s_cyc_i  in  1  bridge Wishbone cycle
- s_stb_i  in  1  bridge strobe
- s_we_i  in  1  bridge write enable
- s_adr_i  in  ADDR_WIDTH  bridge byte address
- s_dat_i  in  DATA_WIDTH  bridge write data
- s_sel_mem_i  in  1  target memory: 0 = instruction, 1 = data
- s_dat_o  out  DATA_WIDTH  read data returned to the bridge
- s_ack_o  out  1  bridge acknowledge, one-cycle pulse
- s_err_o  out  1  bridge error, one-cycle pulse
- core_pc_i  in  ADDR_WIDTH  fetch address
- core_data_addr_i  in  ADDR_WIDTH  data address
- core_mem_write_i  in  1  core store
- core_write_data_i  in  DATA_WIDTH  store data
- core_instr_o  out  DATA_WIDTH  instruction to the core
- core_read_data_o  out  DATA_WIDTH  load data to the core
- core_stall_o  out  1  freezes the core pipeline
- im_cyc_o, im_stb_o, im_we_o  out  1  instruction memory control
- im_adr_o  out  MEM_ADDR_WIDTH  instruction memory word address
- im_dat_o  out  DATA_WIDTH  instruction memory write data
- im_dat_i  in  DATA_WIDTH  instruction memory read data
- im_ack_i  in  1  instruction memory ack
- dm_cyc_o, dm_stb_o, dm_we_o, dm_adr_o, dm_dat_o, dm_dat_i, dm_ack_i  same as im_*, for the data memory

Behaviour:
- Word address for every path is addr[MEM_ADDR_WIDTH+1:2]. An address is in range when addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == 0.
- FSM states: CORE, CHECK, BRIDGE, RELEASE.
- Reset (rst low, asynchronous):
  - state = CORE; core_stall_o = 0; s_ack_o = 0; s_err_o = 0; s_dat_o = 0.
  - Held instruction and held data registers = 0; timer = 0; latched request = 0.
- CORE state:
  - im_cyc_o and im_stb_o = 1, im_we_o = 0, im_adr_o from core_pc_i.
  - dm_cyc_o and dm_stb_o = 1, dm_we_o = core_mem_write_i, dm_adr_o from core_data_addr_i, dm_dat_o = core_write_data_i.
  - core_instr_o = im_dat_i and core_read_data_o = dm_dat_i, combinational. Both values are also registered into the held registers every cycle.
  - When s_cyc_i & s_stb_i: latch we, adr, dat and sel_mem; go to CHECK. A core store in the same cycle still completes.
- CHECK (1 cycle):
  - core_stall_o = 1 (registered; high from CHECK through RELEASE).
  - Both memories idle: cyc = stb = we = 0.
  - Out-of-range address: s_err_o pulses on the next cycle, go to RELEASE.
  - Otherwise: timer = 0, go to BRIDGE.
- BRIDGE:
  - Only the selected memory is driven: cyc = stb = 1, we and adr/dat from the latched request. The other memory stays idle.
  - Selected ack = 1: s_dat_o captures the memory read data (reads only; writes leave s_dat_o unchanged), s_ack_o pulses for exactly one cycle, go to RELEASE.
  - Timer reaches TIMEOUT with no ack: s_err_o pulses for one cycle, s_ack_o stays 0, go to RELEASE.
- RELEASE (1 cycle):
  - Memories idle; s_cyc_i and s_stb_i are ignored.
  - Next state is CORE; core_stall_o drops on entry to CORE.
- While core_stall_o = 1: core_instr_o and core_read_data_o present the held registers, and core writes are suppressed.
- s_ack_o and s_err_o are never high in the same cycle.
- Back-to-back bridge requests: each one passes through CORE for at least one cycle between transfers.
- Reset asserted mid-transfer aborts it: no ack, no error, stall clears immediately.

Test Plan:
- Idle core fetch: core_pc_i = 0x8, im_dat_i = 0x00500093 → im_adr_o = 2, core_instr_o = 0x00500093, core_stall_o = 0.
- Bridge write to data memory: s_adr_i = 0x10, s_dat_i = 0xDEADBEEF, s_we_i = 1, sel = 1, memory acks 1 cycle after stb → dm_adr_o = 4, dm_we_o = 1; s_ack_o pulses once; stall is high for 4 cycles; im_cyc_o = 0 during BRIDGE.
- Bridge read from instruction memory: addr 0x4, im_dat_i = 0x12345678 → s_dat_o = 0x12345678 with s_ack_o; core_instr_o holds its pre-stall value throughout.
- Out-of-range address: s_adr_i = 0x1000 → s_err_o pulses in the cycle after CHECK; no memory cyc asserted; s_ack_o = 0.
- Timeout: TIMEOUT = 4, ack tied low → s_err_o pulses after 4 BRIDGE cycles, then stall releases.
- Reset mid-BRIDGE: rst low while waiting for ack → state = CORE, core_stall_o = 0, s_ack_o = s_err_o = 0 immediately.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | wb_mem_arbiter: shares instruction/data memories between core and bridge |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  // bridge slave port
  input  logic                      s_cyc_i,
  input  logic                      s_stb_i,
  input  logic                      s_we_i,
  input  logic [ADDR_WIDTH-1:0]     s_adr_i,
  input  logic [DATA_WIDTH-1:0]     s_dat_i,
  input  logic                      s_sel_mem_i,
  output logic [DATA_WIDTH-1:0]     s_dat_o,
  output logic                      s_ack_o,
  output logic                      s_err_o,
  // core port
  input  logic [ADDR_WIDTH-1:0]     core_pc_i,
  input  logic [ADDR_WIDTH-1:0]     core_data_addr_i,
  input  logic                      core_mem_write_i,
  input  logic [DATA_WIDTH-1:0]     core_write_data_i,
  output logic [DATA_WIDTH-1:0]     core_instr_o,
  output logic [DATA_WIDTH-1:0]     core_read_data_o,
  output logic                      core_stall_o,
  // instruction memory master port
  output logic                      im_cyc_o,
  output logic                      im_stb_o,
  output logic                      im_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] im_adr_o,
  output logic [DATA_WIDTH-1:0]     im_dat_o,
  input  logic [DATA_WIDTH-1:0]     im_dat_i,
  input  logic                      im_ack_i,
  // data memory master port
  output logic                      dm_cyc_o,
  output logic                      dm_stb_o,
  output logic                      dm_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] dm_adr_o,
  output logic [DATA_WIDTH-1:0]     dm_dat_o,
  input  logic [DATA_WIDTH-1:0]     dm_dat_i,
  input  logic                      dm_ack_i
);

  typedef enum logic [1:0] {
    ST_CORE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_BRIDGE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Timer counts completed BRIDGE cycles; the last permitted cycle is TIMEOUT-1.
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  state_t                    r_state;
  state_t                    w_next_state;

  logic                      r_req_we;
  logic                      r_req_sel;
  logic                      r_req_oor;
  logic [MEM_ADDR_WIDTH-1:0] r_req_adr;
  logic [DATA_WIDTH-1:0]     r_req_dat;

  logic [7:0]                r_timer;
  logic                      r_stall;
  logic                      r_ack;
  logic                      r_err;
  logic [DATA_WIDTH-1:0]     r_s_dat;
  logic [DATA_WIDTH-1:0]     r_held_instr;
  logic [DATA_WIDTH-1:0]     r_held_data;

  logic                      w_bridge_req;
  logic                      w_sel_ack;
  logic [DATA_WIDTH-1:0]     w_sel_dat;
  logic                      w_timeout;
  logic                      w_unused_addr_bits;

  assign w_bridge_req = s_cyc_i & s_stb_i;
  assign w_sel_ack    = r_req_sel ? dm_ack_i : im_ack_i;
  assign w_sel_dat    = r_req_sel ? dm_dat_i : im_dat_i;
  assign w_timeout    = (r_timer == c_timeout_last);

  // Byte-lane bits and core upper address bits carry no meaning here.
  assign w_unused_addr_bits = ^{s_adr_i[1:0], core_pc_i[1:0], core_data_addr_i[1:0],
                                core_pc_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                                core_data_addr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CORE:    if (w_bridge_req) w_next_state = ST_CHECK;
      ST_CHECK:   w_next_state = r_req_oor ? ST_RELEASE : ST_BRIDGE;
      ST_BRIDGE:  if (w_sel_ack || w_timeout) w_next_state = ST_RELEASE;
      ST_RELEASE: w_next_state = ST_CORE;
      default:    w_next_state = ST_CORE;
    endcase
  end

  always_comb begin
    im_cyc_o = 1'b0;
    im_stb_o = 1'b0;
    im_we_o  = 1'b0;
    im_adr_o = '0;
    im_dat_o = '0;
    dm_cyc_o = 1'b0;
    dm_stb_o = 1'b0;
    dm_we_o  = 1'b0;
    dm_adr_o = '0;
    dm_dat_o = '0;
    case (r_state)
      ST_CORE: begin
        im_cyc_o = 1'b1;
        im_stb_o = 1'b1;
        im_adr_o = core_pc_i[MEM_ADDR_WIDTH+1:2];
        dm_cyc_o = 1'b1;
        dm_stb_o = 1'b1;
        dm_we_o  = core_mem_write_i;
        dm_adr_o = core_data_addr_i[MEM_ADDR_WIDTH+1:2];
        dm_dat_o = core_write_data_i;
      end
      ST_BRIDGE: begin
        if (r_req_sel) begin
          dm_cyc_o = 1'b1;
          dm_stb_o = 1'b1;
          dm_we_o  = r_req_we;
          dm_adr_o = r_req_adr;
          dm_dat_o = r_req_dat;
        end else begin
          im_cyc_o = 1'b1;
          im_stb_o = 1'b1;
          im_we_o  = r_req_we;
          im_adr_o = r_req_adr;
          im_dat_o = r_req_dat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_CORE;
      r_stall      <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_s_dat      <= '0;
      r_held_instr <= '0;
      r_held_data  <= '0;
      r_timer      <= '0;
      r_req_we     <= 1'b0;
      r_req_sel    <= 1'b0;
      r_req_oor    <= 1'b0;
      r_req_adr    <= '0;
      r_req_dat    <= '0;
    end else begin
      r_state <= w_next_state;
      r_stall <= (w_next_state != ST_CORE);
      r_ack   <= (r_state == ST_BRIDGE) && w_sel_ack;
      r_err   <= ((r_state == ST_CHECK) && r_req_oor) ||
                 ((r_state == ST_BRIDGE) && !w_sel_ack && w_timeout);

      if (r_state == ST_CORE) begin
        r_held_instr <= im_dat_i;
        r_held_data  <= dm_dat_i;
        if (w_bridge_req) begin
          r_req_we  <= s_we_i;
          r_req_sel <= s_sel_mem_i;
          r_req_oor <= |s_adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
          r_req_adr <= s_adr_i[MEM_ADDR_WIDTH+1:2];
          r_req_dat <= s_dat_i;
        end
      end

      if (r_state == ST_CHECK) begin
        r_timer <= '0;
      end else if ((r_state == ST_BRIDGE) && !w_sel_ack) begin
        r_timer <= r_timer + 8'd1;
      end

      if ((r_state == ST_BRIDGE) && w_sel_ack && !r_req_we) begin
        r_s_dat <= w_sel_dat;
      end
    end
  end

  assign s_dat_o          = r_s_dat;
  assign s_ack_o          = r_ack;
  assign s_err_o          = r_err;
  assign core_stall_o     = r_stall;
  assign core_instr_o     = r_stall ? r_held_instr : im_dat_i;
  assign core_read_data_o = r_stall ? r_held_data  : dm_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_wb_mem_arbiter: directed self-checking bench for wb_mem_arbiter       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        s_cyc_i, s_stb_i, s_we_i, s_sel_mem_i;
  logic [31:0] s_adr_i, s_dat_i, s_dat_o;
  logic        s_ack_o, s_err_o;
  logic [31:0] core_pc_i, core_data_addr_i, core_write_data_i;
  logic        core_mem_write_i;
  logic [31:0] core_instr_o, core_read_data_o;
  logic        core_stall_o;
  logic        im_cyc_o, im_stb_o, im_we_o, im_ack_i;
  logic [9:0]  im_adr_o;
  logic [31:0] im_dat_o, im_dat_i;
  logic        dm_cyc_o, dm_stb_o, dm_we_o, dm_ack_i;
  logic [9:0]  dm_adr_o;
  logic [31:0] dm_dat_o, dm_dat_i;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  int ack_cnt = 0;
  int stall_base;
  int ack_base;

  wb_mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
    .s_dat_i(s_dat_i), .s_sel_mem_i(s_sel_mem_i), .s_dat_o(s_dat_o),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .core_pc_i(core_pc_i), .core_data_addr_i(core_data_addr_i),
    .core_mem_write_i(core_mem_write_i), .core_write_data_i(core_write_data_i),
    .core_instr_o(core_instr_o), .core_read_data_o(core_read_data_o),
    .core_stall_o(core_stall_o),
    .im_cyc_o(im_cyc_o), .im_stb_o(im_stb_o), .im_we_o(im_we_o), .im_adr_o(im_adr_o),
    .im_dat_o(im_dat_o), .im_dat_i(im_dat_i), .im_ack_i(im_ack_i),
    .dm_cyc_o(dm_cyc_o), .dm_stb_o(dm_stb_o), .dm_we_o(dm_we_o), .dm_adr_o(dm_adr_o),
    .dm_dat_o(dm_dat_o), .dm_dat_i(dm_dat_i), .dm_ack_i(dm_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_stall_o) stall_cnt++;
    if (s_ack_o) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bridge_req(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic sel);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_adr_i = adr;  s_dat_i = dat;  s_sel_mem_i = sel;
  endtask

  task automatic bridge_drop();
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bridge_drop();
    s_adr_i = '0; s_dat_i = '0; s_sel_mem_i = 1'b0;
    core_pc_i = '0; core_data_addr_i = '0; core_mem_write_i = 1'b0; core_write_data_i = '0;
    im_dat_i = '0; im_ack_i = 1'b0; dm_dat_i = '0; dm_ack_i = 1'b0;

    // reset state
    step(); step();
    chk("rst_stall", 32'(core_stall_o), 32'd0);
    chk("rst_ack",   32'(s_ack_o), 32'd0);
    chk("rst_err",   32'(s_err_o), 32'd0);
    chk("rst_sdat",  s_dat_o, 32'd0);
    #2 rst = 1'b1;

    // idle core fetch and store
    step();
    core_pc_i = 32'h8; im_dat_i = 32'h00500093;
    core_data_addr_i = 32'h20; dm_dat_i = 32'hCAFEF00D;
    core_mem_write_i = 1'b1; core_write_data_i = 32'h0000AB12;
    #1;
    chk("fetch_adr",   32'(im_adr_o), 32'd2);
    chk("fetch_instr", core_instr_o, 32'h00500093);
    chk("fetch_stall", 32'(core_stall_o), 32'd0);
    chk("fetch_imcyc", 32'(im_cyc_o), 32'd1);
    chk("core_dmadr",  32'(dm_adr_o), 32'd8);
    chk("core_dmwe",   32'(dm_we_o), 32'd1);
    chk("core_dmdat",  dm_dat_o, 32'h0000AB12);
    chk("core_rdata",  core_read_data_o, 32'hCAFEF00D);

    // bridge write to data memory, ack one cycle after stb
    bridge_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    stall_base = stall_cnt; ack_base = ack_cnt;
    step();                                   // CHECK
    im_dat_i = 32'h22222222; dm_dat_i = 32'h11111111;
    #1;
    chk("wr_chk_stall", 32'(core_stall_o), 32'd1);
    chk("wr_chk_dmcyc", 32'(dm_cyc_o), 32'd0);
    chk("wr_chk_dmwe",  32'(dm_we_o), 32'd0);
    chk("wr_chk_imcyc", 32'(im_cyc_o), 32'd0);
    chk("wr_held_instr", core_instr_o, 32'h00500093);
    chk("wr_held_data",  core_read_data_o, 32'hCAFEF00D);
    step();                                   // BRIDGE, first cycle
    chk("wr_br_dmcyc", 32'(dm_cyc_o), 32'd1);
    chk("wr_br_dmwe",  32'(dm_we_o), 32'd1);
    chk("wr_br_dmadr", 32'(dm_adr_o), 32'd4);
    chk("wr_br_dmdat", dm_dat_o, 32'hDEADBEEF);
    chk("wr_br_imcyc", 32'(im_cyc_o), 32'd0);
    step();                                   // BRIDGE, memory acks
    chk("wr_br2_ack", 32'(s_ack_o), 32'd0);
    dm_ack_i = 1'b1;
    step();                                   // RELEASE
    dm_ack_i = 1'b0;
    bridge_drop();
    chk("wr_ack",     32'(s_ack_o), 32'd1);
    chk("wr_noerr",   32'(s_err_o), 32'd0);
    chk("wr_rel_cyc", 32'(dm_cyc_o), 32'd0);
    chk("wr_sdat",    s_dat_o, 32'd0);
    step();                                   // CORE
    chk("wr_end_stall", 32'(core_stall_o), 32'd0);
    chk("wr_end_ack",   32'(s_ack_o), 32'd0);
    chk("wr_live_data", core_read_data_o, 32'h11111111);
    chk("wr_stall_cycles", 32'(stall_cnt - stall_base), 32'd4);
    chk("wr_ack_pulses",   32'(ack_cnt - ack_base), 32'd1);

    // bridge read from instruction memory
    core_mem_write_i = 1'b0;
    bridge_req(1'b0, 32'h4, 32'h0, 1'b0);
    step();                                   // CHECK
    im_dat_i = 32'h12345678;
    #1;
    chk("rd_chk_instr", core_instr_o, 32'h22222222);
    step();                                   // BRIDGE
    chk("rd_imcyc", 32'(im_cyc_o), 32'd1);
    chk("rd_imwe",  32'(im_we_o), 32'd0);
    chk("rd_imadr", 32'(im_adr_o), 32'd1);
    chk("rd_dmcyc", 32'(dm_cyc_o), 32'd0);
    chk("rd_br_instr", core_instr_o, 32'h22222222);
    im_ack_i = 1'b1;
    step();                                   // RELEASE
    im_ack_i = 1'b0;
    bridge_drop();
    chk("rd_ack",   32'(s_ack_o), 32'd1);
    chk("rd_sdat",  s_dat_o, 32'h12345678);
    chk("rd_rel_instr", core_instr_o, 32'h22222222);
    step();                                   // CORE
    chk("rd_live_instr", core_instr_o, 32'h12345678);
    chk("rd_end_stall",  32'(core_stall_o), 32'd0);
    chk("rd_sdat_keep",  s_dat_o, 32'h12345678);

    // out-of-range address
    bridge_req(1'b0, 32'h1000, 32'h0, 1'b1);
    step();                                   // CHECK
    chk("oor_imcyc", 32'(im_cyc_o), 32'd0);
    chk("oor_dmcyc", 32'(dm_cyc_o), 32'd0);
    chk("oor_chk_err", 32'(s_err_o), 32'd0);
    step();                                   // RELEASE
    bridge_drop();
    chk("oor_err",   32'(s_err_o), 32'd1);
    chk("oor_ack",   32'(s_ack_o), 32'd0);
    chk("oor_dmcyc_rel", 32'(dm_cyc_o), 32'd0);
    step();                                   // CORE
    chk("oor_err_drop", 32'(s_err_o), 32'd0);
    chk("oor_stall",    32'(core_stall_o), 32'd0);

    // timeout with TIMEOUT = 4, request left asserted to exercise RELEASE
    bridge_req(1'b0, 32'h8, 32'h0, 1'b1);
    step();                                   // CHECK
    for (int i = 0; i < 4; i++) begin
      step();                                 // BRIDGE cycles 1..4
      chk("to_dmcyc", 32'(dm_cyc_o), 32'd1);
      chk("to_noerr", 32'(s_err_o), 32'd0);
    end
    step();                                   // RELEASE
    chk("to_err",   32'(s_err_o), 32'd1);
    chk("to_ack",   32'(s_ack_o), 32'd0);
    chk("to_stall", 32'(core_stall_o), 32'd1);
    step();                                   // CORE, request still held
    chk("to_rel_stall", 32'(core_stall_o), 32'd0);
    chk("to_err_drop",  32'(s_err_o), 32'd0);
    step();                                   // CHECK of held request
    chk("b2b_stall", 32'(core_stall_o), 32'd1);
    step();                                   // BRIDGE

    // reset asserted mid-BRIDGE
    chk("mid_dmcyc", 32'(dm_cyc_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(core_stall_o), 32'd0);
    chk("mid_rst_ack",   32'(s_ack_o), 32'd0);
    chk("mid_rst_err",   32'(s_err_o), 32'd0);
    chk("mid_rst_sdat",  s_dat_o, 32'd0);
    chk("mid_rst_imcyc", 32'(im_cyc_o), 32'd1);
    bridge_drop();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_stall", 32'(core_stall_o), 32'd0);
    chk("post_rst_err",   32'(s_err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
